packet_fifo_sender: RTL and testbench
=====================================

Name: packet_fifo_sender

Overview:
- Single-clock packet buffer with a serialising transmitter.
- The write side assembles byte-addressed packets into one of DEPTH slots and commits each slot with a strobe.
- The read side drains committed slots in FIFO order and streams each packet one byte per cycle on packet_out, qualified by packet_valid.
- Sits between the router's input assembly logic and the output link.

Parameters:
- DEPTH, 4: number of packet slots.
- WIDTH, 11: bytes per slot (maximum packet length).
- UWIDTH, 8: byte width.
- PTR_SZ, 2: slot-pointer width, log2(DEPTH).
- PTR_IN_SZ, 4: in-slot byte-index width, ceil(log2(WIDTH)).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- winc  in  1  commit strobe for the current write slot.
- waddr_in  in  PTR_IN_SZ  byte index within the write slot.
- wdata  in  UWIDTH  byte to store.
- wfull  out  1  all DEPTH slots committed and not yet sent.
- rempty  out  1  no committed slot pending.
- packet_valid  out  1  packet_out carries a valid byte this cycle.
- packet_out  out  UWIDTH  serialised packet byte.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Packet layout in a slot: [0] source_id, [1] dest_id, [2] size, [3..2+size] data, [3+size] crc.
- Storage: DEPTH x WIDTH x UWIDTH array, not reset.
- Write pointer wptr and read pointer rptr are PTR_SZ+1 bits each (wrap bit included).
- count = wptr - rptr. wfull = (count == DEPTH); rempty = (count == 0). Both are combinational from registered pointers.
- Byte write: every cycle with !wfull, mem[wptr][waddr_in] <= wdata.
  - If waddr_in >= WIDTH, the write is ignored.
  - Bytes may be rewritten any number of times before commit.
- Commit: winc && !wfull at an edge also writes that cycle's byte, then increments wptr.
- winc && wfull: both the byte and the commit are dropped; no state changes.
- Transmit FSM states: IDLE, SEND, POP.
  - IDLE: if !rempty, go to SEND with index = 0; else stay.
  - SEND: at each edge, packet_out <= mem[rptr][index] and packet_valid <= 1.
    - At index 2, latch dsz = min(byte, WIDTH-4).
    - index increments each edge.
    - After the byte at index 3+dsz (crc) is registered, go to POP.
  - POP: rptr increments at that edge, packet_valid <= 0, go to IDLE.
- Total bytes per packet = 4 + dsz.
  - size = 0 emits src, dst, size, crc.
  - size > WIDTH-4 is clamped to WIDTH-4, so crc is read from index WIDTH-1.
- Latency: commit at edge N, then IDLE->SEND at edge N+1. The first byte is visible after edge N+2. packet_valid stays high for 4+dsz consecutive cycles.
- Inter-packet gap: packet_valid is low for at least 2 cycles (POP, IDLE).
- packet_out holds its last value while packet_valid is low.
- Simultaneous commit and pop in the same edge: both pointers advance; count is unchanged.
- The slot under transmission is never overwritten: writes target wptr, which equals rptr only when empty or full, and full blocks writes.
- Reset (any time, including mid-packet), at the next edge:
  - wptr = rptr = 0, state IDLE, index 0, dsz 0.
  - packet_valid 0, packet_out 0.
  - wfull 0, rempty 1.
  - Memory contents are kept.

Decomposition:
- Shared package pfs_pkg holds:
  - the parameter defaults;
  - the byte-offset constants SRC_IDX = 0, DST_IDX = 1, SIZE_IDX = 2, DATA_IDX = 3;
  - the FSM state enum {IDLE, SEND, POP}.
- One natural sub-module, pfs_slot_mem: slot storage plus pointer/flag logic, with a combinational read port addressed by (rptr, index).
- The FSM stays in the top level.

Test Plan:
- Reset: assert rst for 2 cycles -> wfull=0, rempty=1, packet_valid=0, packet_out=0.
- Packet 1: write 10, 160, 3, 0, 1, 2 at indices 0-5, then 15 at index 6 with winc -> after the commit edge plus 2, packet_out = 10, 160, 3, 0, 1, 2, 15 with packet_valid high for exactly 7 cycles; rempty=1 after POP.
- Packet 2 written while packet 1 streams: 100, 10, 4, 0, 1, 2, 3, 55, committed at index 7 -> streamed intact after packet 1, gap >= 2 cycles, 8 valid bytes.
- Overflow: winc on 6 consecutive cycles from empty -> wfull asserts after the 4th commit; the 5th and 6th commits and their bytes are dropped; exactly 4 packets are emitted, and wfull drops at the first POP.
- Clamp: slot with size = 200 and crc = 0xAB at index 10 -> 11 bytes emitted, the last being 0xAB.
- Mid-packet reset: assert rst on the 3rd valid byte -> packet_valid=0 and rempty=1 after that edge; no further bytes emitted.

Source files
------------

// File: rtl/pfs_pkg.sv
// Shared defaults, packet byte offsets and transmit-FSM state encoding
// for the packet FIFO sender.
package pfs_pkg;

  localparam int PFS_DEPTH     = 4;
  localparam int PFS_WIDTH     = 11;
  localparam int PFS_UWIDTH    = 8;
  localparam int PFS_PTR_SZ    = 2;
  localparam int PFS_PTR_IN_SZ = 4;

  // Byte offsets inside a slot; the crc follows the data at DATA_IDX + size.
  localparam int SRC_IDX  = 0;
  localparam int DST_IDX  = 1;
  localparam int SIZE_IDX = 2;
  localparam int DATA_IDX = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    POP  = 2'd2
  } state_e;

endpackage

// File: rtl/pfs_slot_mem.sv
// Packet slot storage with wrap-bit write/read pointers and full/empty flags.
// The read port is combinational and addressed by (rptr, ridx_i).
module pfs_slot_mem
  import pfs_pkg::*;
#(
  parameter int DEPTH     = PFS_DEPTH,
  parameter int WIDTH     = PFS_WIDTH,
  parameter int UWIDTH    = PFS_UWIDTH,
  parameter int PTR_SZ    = PFS_PTR_SZ,
  parameter int PTR_IN_SZ = PFS_PTR_IN_SZ
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 winc_i,
  input  logic [PTR_IN_SZ-1:0] waddr_i,
  input  logic [UWIDTH-1:0]    wdata_i,
  input  logic                 pop_i,
  input  logic [PTR_IN_SZ-1:0] ridx_i,
  output logic [UWIDTH-1:0]    rdata_o,
  output logic                 wfull_o,
  output logic                 rempty_o
);

  localparam logic [PTR_SZ:0]    FULL_CNT = (PTR_SZ+1)'(DEPTH);
  localparam logic [PTR_IN_SZ-1:0] LAST_IDX = PTR_IN_SZ'(WIDTH - 1);

  logic [UWIDTH-1:0] mem_q [DEPTH][WIDTH];
  logic [PTR_SZ:0]   wptr_q, wptr_d;
  logic [PTR_SZ:0]   rptr_q, rptr_d;
  logic [PTR_SZ:0]   count;
  logic              wr_en;

  assign count    = wptr_q - rptr_q;
  assign wfull_o  = (count == FULL_CNT);
  assign rempty_o = (count == '0);

  // A full FIFO drops both the byte and the commit, so the slot being
  // streamed (rptr == wptr slot when full) can never be touched.
  assign wr_en  = !rst && !wfull_o;
  assign wptr_d = wptr_q + (PTR_SZ+1)'(wr_en && winc_i);
  assign rptr_d = rptr_q + (PTR_SZ+1)'(pop_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && (waddr_i <= LAST_IDX)) begin
      mem_q[wptr_q[PTR_SZ-1:0]][waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = (ridx_i <= LAST_IDX) ? mem_q[rptr_q[PTR_SZ-1:0]][ridx_i] : '0;

endmodule

// File: rtl/packet_fifo_sender.sv
// Packet FIFO with a byte-serial transmitter: drains committed slots in
// order, emitting src, dst, size, data[0..dsz-1], crc one byte per cycle.
module packet_fifo_sender
  import pfs_pkg::*;
#(
  parameter int DEPTH     = PFS_DEPTH,
  parameter int WIDTH     = PFS_WIDTH,
  parameter int UWIDTH    = PFS_UWIDTH,
  parameter int PTR_SZ    = PFS_PTR_SZ,
  parameter int PTR_IN_SZ = PFS_PTR_IN_SZ
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 winc,
  input  logic [PTR_IN_SZ-1:0] waddr_in,
  input  logic [UWIDTH-1:0]    wdata,
  output logic                 wfull,
  output logic                 rempty,
  output logic                 packet_valid,
  output logic [UWIDTH-1:0]    packet_out
);

  localparam logic [PTR_IN_SZ-1:0] MAX_DSZ = PTR_IN_SZ'(WIDTH - 4);
  localparam logic [UWIDTH-1:0]    MAX_SZB = UWIDTH'(WIDTH - 4);
  localparam logic [PTR_IN_SZ-1:0] SIZE_I  = PTR_IN_SZ'(SIZE_IDX);
  localparam logic [PTR_IN_SZ-1:0] DATA_I  = PTR_IN_SZ'(DATA_IDX);

  state_e               state_q, state_d;
  logic [PTR_IN_SZ-1:0] idx_q, idx_d;
  logic [PTR_IN_SZ-1:0] dsz_q, dsz_d;
  logic                 valid_q, valid_d;
  logic [UWIDTH-1:0]    out_q, out_d;
  logic                 pop;
  logic [UWIDTH-1:0]    rdata;
  logic                 last_byte;

  pfs_slot_mem #(
    .DEPTH    (DEPTH),
    .WIDTH    (WIDTH),
    .UWIDTH   (UWIDTH),
    .PTR_SZ   (PTR_SZ),
    .PTR_IN_SZ(PTR_IN_SZ)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .winc_i  (winc),
    .waddr_i (waddr_in),
    .wdata_i (wdata),
    .pop_i   (pop),
    .ridx_i  (idx_q),
    .rdata_o (rdata),
    .wfull_o (wfull),
    .rempty_o(rempty)
  );

  // dsz is only latched at the size byte, but DATA_I + dsz is always beyond
  // the header indices, so a stale dsz can never end the packet early.
  assign last_byte = (idx_q == DATA_I + dsz_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dsz_q   <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dsz_q   <= dsz_d;
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rempty) state_d = SEND;
      SEND:    if (last_byte) state_d = POP;
      POP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    dsz_d   = dsz_q;
    valid_d = valid_q;
    out_d   = out_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        idx_d   = '0;
        valid_d = 1'b0;
      end
      SEND: begin
        out_d   = rdata;
        valid_d = 1'b1;
        idx_d   = idx_q + PTR_IN_SZ'(1);
        if (idx_q == SIZE_I) begin
          dsz_d = (rdata > MAX_SZB) ? MAX_DSZ : rdata[PTR_IN_SZ-1:0];
        end
      end
      POP: begin
        idx_d   = '0;
        valid_d = 1'b0;
        pop     = 1'b1;
      end
      default: begin
        idx_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign packet_valid = valid_q;
  assign packet_out   = out_q;

endmodule

// File: tb/tb_packet_fifo_sender.sv
// Bench for packet_fifo_sender: a slot/queue model predicts every output per
// cycle; directed scenarios add literal checks on the emitted byte stream.
module tb_packet_fifo_sender;

  localparam int DEPTH = 4;
  localparam int WIDTH = 11;

  logic       clk = 1'b0;
  logic       rst;
  logic       winc;
  logic [3:0] waddr;
  logic [7:0] wdata;
  logic       wfull, rempty, packet_valid;
  logic [7:0] packet_out;

  packet_fifo_sender dut (
    .clk         (clk),
    .rst         (rst),
    .winc        (winc),
    .waddr_in    (waddr),
    .wdata       (wdata),
    .wfull       (wfull),
    .rempty      (rempty),
    .packet_valid(packet_valid),
    .packet_out  (packet_out)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic       v;
    logic [7:0] b;
    logic       pop;
  } ent_t;

  logic [7:0]             mm [DEPTH][WIDTH];
  logic [WIDTH*8-1:0]     pend_q[$];
  ent_t                   sched[$];
  int                     m_wptr = 0;
  int                     m_count = 0;
  logic                   exp_v = 1'b0;
  logic [7:0]             exp_o = 8'd0;
  bit                     model_ok = 1'b0;
  int                     cyc = 0;

  task automatic model_step();
    logic [WIDTH*8-1:0] pk;
    int   sz;
    bit   full, empty, do_pop;
    ent_t e;
    cyc++;
    if (rst) begin
      m_wptr = 0; m_count = 0;
      pend_q.delete(); sched.delete();
      exp_v = 1'b0; exp_o = 8'd0;
      model_ok = 1'b1;
      return;
    end
    full   = (m_count == DEPTH);
    empty  = (m_count == 0);
    do_pop = 1'b0;
    // A packet occupies: one edge leaving idle, 4+dsz byte edges, one pop edge.
    if (sched.size() == 0 && !empty) begin
      pk = pend_q.pop_front();
      sz = int'(pk[2*8 +: 8]);
      if (sz > WIDTH - 4) sz = WIDTH - 4;
      sched.push_back('{v: 1'b0, b: 8'd0, pop: 1'b0});
      for (int k = 0; k <= 3 + sz; k++) sched.push_back('{v: 1'b1, b: pk[k*8 +: 8], pop: 1'b0});
      sched.push_back('{v: 1'b0, b: 8'd0, pop: 1'b1});
    end
    if (sched.size() > 0) begin
      e = sched.pop_front();
      if (e.pop) begin
        do_pop = 1'b1; exp_v = 1'b0;
      end else if (e.v) begin
        exp_v = 1'b1; exp_o = e.b;
      end else begin
        exp_v = 1'b0;
      end
    end
    if (!full) begin
      if (int'(waddr) < WIDTH) mm[m_wptr][waddr] = wdata;
      if (winc) begin
        for (int k = 0; k < WIDTH; k++) pk[k*8 +: 8] = mm[m_wptr][k];
        pend_q.push_back(pk);
        m_wptr = (m_wptr + 1) % DEPTH;
        m_count++;
      end
    end
    if (do_pop) m_count--;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      chk("valid",  int'(packet_valid), int'(exp_v));
      chk("out",    int'(packet_out),   int'(exp_o));
      chk("wfull",  int'(wfull),        int'(m_count == DEPTH));
      chk("rempty", int'(rempty),       int'(m_count == 0));
    end
  end

  // ---------------- stream recorder ----------------
  logic [7:0] rec_q[$];
  int         runs[$];
  int         starts_q[$];
  int         fall_cyc[$];
  int         fall_wfull[$];
  int         run = 0;
  logic       prev_v = 1'b0;

  initial forever begin
    @(negedge clk);
    if (packet_valid) begin
      rec_q.push_back(packet_out);
      run++;
      if (!prev_v) starts_q.push_back(cyc);
    end else if (prev_v) begin
      runs.push_back(run);
      run = 0;
      fall_cyc.push_back(cyc);
      fall_wfull.push_back(int'(wfull));
    end
    prev_v = packet_valid;
  end

  task automatic clear_rec();
    rec_q.delete(); runs.delete(); starts_q.delete();
    fall_cyc.delete(); fall_wfull.delete();
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic w, input logic [3:0] a, input logic [7:0] d);
    winc = w; waddr = a; wdata = d;
    @(posedge clk);
    #2;
  endtask

  // waddr 15 is outside the slot, so idle cycles leave memory untouched.
  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'd15, 8'd0);
  endtask

  task automatic wait_runs(input string name, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (runs.size() >= n) break;
      idle(1);
    end
    chk(name, runs.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] exp_p12 [15] = '{8'd10, 8'd160, 8'd3, 8'd0, 8'd1, 8'd2, 8'd15,
                               8'd100, 8'd10, 8'd4, 8'd0, 8'd1, 8'd2, 8'd3, 8'd55};
  logic [7:0] p1 [7] = '{8'd10, 8'd160, 8'd3, 8'd0, 8'd1, 8'd2, 8'd15};
  logic [7:0] p2 [8] = '{8'd100, 8'd10, 8'd4, 8'd0, 8'd1, 8'd2, 8'd3, 8'd55};

  initial begin
    int commit_cyc, vc, s0;
    rst = 1'b1; winc = 1'b0; waddr = 4'd15; wdata = 8'd0;

    // Reset
    step(1'b0, 4'd15, 8'd0);
    step(1'b0, 4'd15, 8'd0);
    chk("rst_wfull",  int'(wfull), 0);
    chk("rst_rempty", int'(rempty), 1);
    chk("rst_valid",  int'(packet_valid), 0);
    chk("rst_out",    int'(packet_out), 0);
    rst = 1'b0;

    // Fill every slot fully so later partial writes never read undefined bytes.
    for (int s = 0; s < DEPTH; s++)
      for (int k = 0; k < WIDTH; k++)
        step(k == WIDTH - 1, 4'(k), (k == 2) ? 8'(s) : 8'(s * 16 + k));
    idle(60);
    chk("init_rempty", int'(rempty), 1);

    // Packet 1, with packet 2 written while packet 1 streams
    clear_rec();
    for (int k = 0; k < 6; k++) step(1'b0, 4'(k), p1[k]);
    step(1'b1, 4'd6, p1[6]);
    commit_cyc = cyc;
    for (int k = 0; k < 8; k++) step(k == 7, 4'(k), p2[k]);
    wait_runs("p12_runs", 2, 60);
    chk("p1_latency", (starts_q.size() > 0) ? starts_q[0] : -1, commit_cyc + 2);
    chk("p1_len", (runs.size() > 0) ? runs[0] : -1, 7);
    chk("p2_len", (runs.size() > 1) ? runs[1] : -1, 8);
    chk("p12_bytes", rec_q.size(), 15);
    for (int i = 0; i < 15; i++)
      chk($sformatf("p12_byte%0d", i), (i < rec_q.size()) ? int'(rec_q[i]) : -1, int'(exp_p12[i]));
    chk("p12_gap_ge2", int'((starts_q.size() > 1 && fall_cyc.size() > 0) ?
                            (starts_q[1] - fall_cyc[0] >= 2) : 1'b0), 1);
    idle(4);
    chk("p12_rempty", int'(rempty), 1);

    // Overflow: six back-to-back commits from empty
    idle(10);
    clear_rec();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      if (i == 2) chk("ovf_notfull3", int'(wfull), 0);
      if (i == 3) chk("ovf_full4", int'(wfull), 1);
    end
    chk("ovf_full6", int'(wfull), 1);
    wait_runs("ovf_runs", 4, 200);
    idle(20);
    chk("ovf_pkts", starts_q.size(), 4);
    chk("ovf_wfull_at_pop", (fall_wfull.size() > 0) ? fall_wfull[0] : -1, 0);
    chk("ovf_rempty", int'(rempty), 1);

    // Clamp: size 200 -> 11 bytes, crc taken from the last index
    clear_rec();
    for (int k = 0; k < WIDTH; k++)
      step(k == WIDTH - 1, 4'(k), (k == 2) ? 8'd200 : (k == WIDTH - 1) ? 8'hAB : 8'(8'h30 + k));
    wait_runs("clamp_runs", 1, 60);
    chk("clamp_len", (runs.size() > 0) ? runs[0] : -1, 11);
    chk("clamp_size", (rec_q.size() > 2) ? int'(rec_q[2]) : -1, 200);
    chk("clamp_crc", (rec_q.size() > 10) ? int'(rec_q[10]) : -1, 8'hAB);
    idle(6);

    // Mid-packet reset with a second packet still pending
    for (int k = 0; k < 9; k++) step(k == 8, 4'(k), (k == 2) ? 8'd5 : 8'(8'h50 + k));
    for (int k = 0; k < 5; k++) step(k == 4, 4'(k), (k == 2) ? 8'd1 : 8'(8'h70 + k));
    vc = 0;
    for (int i = 0; i < 40; i++) begin
      if (packet_valid) vc++;
      if (vc == 3) break;
      idle(1);
    end
    chk("mrst_third_byte", vc, 3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("mrst_valid",  int'(packet_valid), 0);
    chk("mrst_rempty", int'(rempty), 1);
    chk("mrst_wfull",  int'(wfull), 0);
    chk("mrst_out",    int'(packet_out), 0);
    s0 = starts_q.size();
    idle(30);
    chk("mrst_no_more", starts_q.size(), s0);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 249) == 0);
      step($urandom_range(0, 5) == 0, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end
    rst = 1'b0;
    idle(120);
    chk("final_rempty", int'(rempty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
